// File: rtl/forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : forward_ctrl
// Description : Operand-forwarding and load-use hazard control for a classic
//               5-stage pipeline. Tracks the instructions in EX, MEM and WB,
//               decodes 3:1 forwarding-mux selects for both EX operands, and
//               raises a single-cycle stall for a load-use dependency.
//               Also keeps a saturating count of stall cycles.
// Ports       :
//   clk_i          - clock, all state updates on the rising edge
//   rst_i          - synchronous active-high reset
//   id_valid_i     - a real instruction is in ID
//   id_rs_i/rt_i   - ID source registers
//   id_rd_i        - ID destination register
//   id_regwrite_i  - ID instruction writes the register file
//   id_memread_i   - ID instruction is a load
//   flush_i        - discard the ID instruction (branch taken)
//   fwd_a_o/b_o    - operand mux selects: 0 = regfile, 1 = EX/MEM, 2 = MEM/WB
//   stall_o        - hold PC and IF/ID, insert a bubble into EX
//   stall_cnt_o    - saturating stall-cycle count
// Revision    : 1.0 - initial release
// ============================================================================
module forward_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [1:0] c_SEL_RF  = 2'd0;
    localparam logic [1:0] c_SEL_MEM = 2'd1;
    localparam logic [1:0] c_SEL_WB  = 2'd2;

    // ------------------------------------------------------------------
    // Pipeline slots
    // ------------------------------------------------------------------
    logic              r_ex_valid,  r_mem_valid,  r_wb_valid;
    logic [REG_AW-1:0] r_ex_rs,     r_mem_rs,     r_wb_rs;
    logic [REG_AW-1:0] r_ex_rt,     r_mem_rt,     r_wb_rt;
    logic [REG_AW-1:0] r_ex_rd,     r_mem_rd,     r_wb_rd;
    logic              r_ex_rw,     r_mem_rw,     r_wb_rw;
    logic              r_ex_mr,     r_mem_mr,     r_wb_mr;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_stall;
    logic              w_ex_load;
    logic              w_mem_src;
    logic              w_wb_src;
    logic              w_ex_take;
    logic [1:0]        w_fwd_a;
    logic [1:0]        w_fwd_b;

    // A load that would feed the ID instruction is still in EX: its data
    // only exists after MEM, so the consumer waits one cycle. Flush
    // suppresses the stall because the consumer is being discarded anyway.
    assign w_ex_load = r_ex_valid && r_ex_mr && (r_ex_rd != '0);
    assign w_stall   = w_ex_load && id_valid_i && !flush_i &&
                       ((r_ex_rd == id_rs_i) || (r_ex_rd == id_rt_i));

    assign w_ex_take = id_valid_i && !flush_i && !w_stall;

    // A slot only supplies forwarded data when it really writes a nonzero
    // register. A load can never reach MEM with a dependent instruction
    // behind it in EX (the stall above separates them), so select 1 never
    // picks up a load address.
    assign w_mem_src = r_mem_valid && r_mem_rw && (r_mem_rd != '0);
    assign w_wb_src  = r_wb_valid  && r_wb_rw  && (r_wb_rd  != '0);

    always_comb begin
        w_fwd_a = c_SEL_RF;
        w_fwd_b = c_SEL_RF;
        if (r_ex_valid) begin
            // MEM is checked first so the newest value wins.
            if (w_mem_src && (r_mem_rd == r_ex_rs)) begin
                w_fwd_a = c_SEL_MEM;
            end else if (w_wb_src && (r_wb_rd == r_ex_rs)) begin
                w_fwd_a = c_SEL_WB;
            end
            if (w_mem_src && (r_mem_rd == r_ex_rt)) begin
                w_fwd_b = c_SEL_MEM;
            end else if (w_wb_src && (r_wb_rd == r_ex_rt)) begin
                w_fwd_b = c_SEL_WB;
            end
        end
    end

    // ------------------------------------------------------------------
    // Slot advance: MEM and WB always move; EX takes ID or a bubble.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ex_valid  <= 1'b0;
            r_mem_valid <= 1'b0;
            r_wb_valid  <= 1'b0;
        end else begin
            r_wb_valid  <= r_mem_valid;
            r_mem_valid <= r_ex_valid;
            r_ex_valid  <= w_ex_take;
        end
    end

    // Payload fields carry no reset; they are meaningless while valid = 0.
    always_ff @(posedge clk_i) begin
        r_wb_rs  <= r_mem_rs;
        r_wb_rt  <= r_mem_rt;
        r_wb_rd  <= r_mem_rd;
        r_wb_rw  <= r_mem_rw;
        r_wb_mr  <= r_mem_mr;
        r_mem_rs <= r_ex_rs;
        r_mem_rt <= r_ex_rt;
        r_mem_rd <= r_ex_rd;
        r_mem_rw <= r_ex_rw;
        r_mem_mr <= r_ex_mr;
        r_ex_rs  <= id_rs_i;
        r_ex_rt  <= id_rt_i;
        r_ex_rd  <= id_rd_i;
        r_ex_rw  <= id_regwrite_i;
        r_ex_mr  <= id_memread_i;
    end

    // ------------------------------------------------------------------
    // Saturating stall counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Source fields of the later slots are kept for pipeline visibility
    // only; nothing downstream of this block decodes them.
    logic w_unused;
    assign w_unused = ^{r_mem_rs, r_mem_rt, r_mem_mr,
                        r_wb_rs, r_wb_rt, r_wb_mr};

    assign fwd_a_o     = w_fwd_a;
    assign fwd_b_o     = w_fwd_b;
    assign stall_o     = w_stall;
    assign stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_forward_ctrl
// Description : Self-checking bench for forward_ctrl. Two instances share the
//               stimulus: one with the default counter width and one with a
//               2-bit counter for saturation. Each table row is one cycle of
//               ID input plus the outputs expected in that same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_forward_ctrl;

    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic          id_valid;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic          id_rw, id_mr, flush;
    logic [1:0]    fwd_a, fwd_b, fwd_a_s, fwd_b_s;
    logic          stall, stall_s;
    logic [15:0]   cnt;
    logic [1:0]    cnt_s;

    forward_ctrl #(.REG_AW(AW), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd),
        .id_regwrite_i(id_rw), .id_memread_i(id_mr), .flush_i(flush),
        .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .stall_o(stall), .stall_cnt_o(cnt)
    );

    forward_ctrl #(.REG_AW(AW), .CNT_W(2)) dut_s (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd),
        .id_regwrite_i(id_rw), .id_memread_i(id_mr), .flush_i(flush),
        .fwd_a_o(fwd_a_s), .fwd_b_o(fwd_b_s), .stall_o(stall_s),
        .stall_cnt_o(cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] rs, rt, rd;
        logic       rw, mr, fl, rs_t;
        logic       chk;
        logic [1:0] ea, eb;
        logic       es;
        int         ec, ecs;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic v, input int rs_, input int rt_,
                                input int rd_, input logic rw, input logic mr,
                                input logic fl, input logic r, input logic chk,
                                input int ea, input int eb, input logic es,
                                input int ec, input int ecs);
        vec_t t;
        t.v = v; t.rs = rs_[4:0]; t.rt = rt_[4:0]; t.rd = rd_[4:0];
        t.rw = rw; t.mr = mr; t.fl = fl; t.rs_t = r; t.chk = chk;
        t.ea = ea[1:0]; t.eb = eb[1:0]; t.es = es; t.ec = ec; t.ecs = ecs;
        return t;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        id_valid = t.v; id_rs = t.rs; id_rt = t.rt; id_rd = t.rd;
        id_rw = t.rw; id_mr = t.mr; flush = t.fl; rst = t.rs_t;
    endtask

    initial begin
        vec_t e;
        rst = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0;
        id_rw = 1'b0; id_mr = 1'b0; flush = 1'b0;

        //          v rs rt rd rw mr fl rst chk ea eb s  cnt sat
        tbl.push_back(mk(0, 0, 0, 0, 0,0,0,1, 0, 0,0,0, 0,0));  // 0 reset
        tbl.push_back(mk(0, 0, 0, 0, 0,0,0,0, 1, 0,0,0, 0,0));  // 1 post-reset
        tbl.push_back(mk(1, 1, 2, 3, 1,0,0,0, 1, 0,0,0, 0,0));  // 2 add r3
        tbl.push_back(mk(1, 3, 4, 6, 1,0,0,0, 1, 0,0,0, 0,0));  // 3 sub rs=r3
        tbl.push_back(mk(0, 0, 0, 0, 0,0,0,0, 1, 1,0,0, 0,0));  // 4 EX->EX fwd
        tbl.push_back(mk(1, 1, 1, 5, 1,0,0,0, 1, 0,0,0, 0,0));  // 5 w r5
        tbl.push_back(mk(1, 8, 9,10, 1,0,0,0, 1, 0,0,0, 0,0));  // 6 unrelated
        tbl.push_back(mk(1,11, 5,12, 1,0,0,0, 1, 0,0,0, 0,0));  // 7 rd rt=r5
        tbl.push_back(mk(0, 0, 0, 0, 0,0,0,0, 1, 0,2,0, 0,0));  // 8 WB fwd
        tbl.push_back(mk(1, 1, 1, 5, 1,0,0,0, 1, 0,0,0, 0,0));  // 9 w r5
        tbl.push_back(mk(1, 1, 1, 5, 1,0,0,0, 1, 0,0,0, 0,0));  // 10 w r5
        tbl.push_back(mk(1,11, 5,12, 1,0,0,0, 1, 0,0,0, 0,0));  // 11 rd rt=r5
        tbl.push_back(mk(0, 0, 0, 0, 0,0,0,0, 1, 0,1,0, 0,0));  // 12 MEM wins
        tbl.push_back(mk(1, 1, 0, 7, 1,1,0,0, 1, 0,0,0, 0,0));  // 13 load r7
        tbl.push_back(mk(1, 7, 2, 8, 1,0,0,0, 1, 0,0,1, 0,0));  // 14 stall
        tbl.push_back(mk(1, 7, 2, 8, 1,0,0,0, 1, 0,0,0, 1,1));  // 15 re-present
        tbl.push_back(mk(0, 0, 0, 0, 0,0,0,0, 1, 2,0,0, 1,1));  // 16 fwd from WB
        tbl.push_back(mk(1, 1, 1, 0, 1,0,0,0, 1, 0,0,0, 1,1));  // 17 w r0
        tbl.push_back(mk(1, 0, 3, 9, 1,0,0,0, 1, 0,0,0, 1,1));  // 18 rd rs=r0
        tbl.push_back(mk(1, 1, 2, 4, 0,0,0,0, 1, 0,0,0, 1,1));  // 19 store r4
        tbl.push_back(mk(1, 4, 1, 9, 1,0,0,0, 1, 0,0,0, 1,1));  // 20 rd rs=r4
        tbl.push_back(mk(0, 0, 0, 0, 0,0,0,0, 1, 0,0,0, 1,1));  // 21 no fwd
        tbl.push_back(mk(1, 1, 1, 2, 1,1,0,0, 1, 0,0,0, 1,1));  // 22 load r2
        tbl.push_back(mk(1, 2, 3, 9, 1,0,1,0, 1, 0,0,0, 1,1));  // 23 flush
        tbl.push_back(mk(0, 0, 0, 0, 0,0,0,0, 1, 0,0,0, 1,1));  // 24 EX bubble
        tbl.push_back(mk(1, 1, 1, 7, 1,1,0,0, 1, 0,0,0, 1,1));  // 25 load r7
        tbl.push_back(mk(1, 1, 7, 8, 1,0,0,0, 1, 0,0,1, 1,1));  // 26 stall #2
        tbl.push_back(mk(1, 1, 7, 8, 1,0,0,0, 1, 0,0,0, 2,2));  // 27
        tbl.push_back(mk(1, 1, 1, 7, 1,1,0,0, 1, 0,2,0, 2,2));  // 28 load r7
        tbl.push_back(mk(1, 1, 7, 8, 1,0,0,0, 1, 0,0,1, 2,2));  // 29 stall #3
        tbl.push_back(mk(1, 1, 7, 8, 1,0,0,0, 1, 0,0,0, 3,3));  // 30
        tbl.push_back(mk(1, 1, 1, 7, 1,1,0,0, 1, 0,2,0, 3,3));  // 31 load r7
        tbl.push_back(mk(1, 1, 7, 8, 1,0,0,0, 1, 0,0,1, 3,3));  // 32 stall #4
        tbl.push_back(mk(1, 1, 7, 8, 1,0,0,0, 1, 0,0,0, 4,3));  // 33 saturated
        tbl.push_back(mk(1, 1, 1, 7, 1,1,0,0, 1, 0,2,0, 4,3));  // 34 load r7
        tbl.push_back(mk(1, 1, 7, 8, 1,0,0,0, 1, 0,0,1, 4,3));  // 35 stall #5
        tbl.push_back(mk(1, 1, 7, 8, 1,0,0,0, 1, 0,0,0, 5,3));  // 36 no wrap
        tbl.push_back(mk(1, 1, 1,11, 1,0,0,0, 1, 0,2,0, 5,3));  // 37 A r11
        tbl.push_back(mk(1, 1, 1,12, 1,0,0,0, 1, 0,0,0, 5,3));  // 38 B r12
        tbl.push_back(mk(1, 1, 1,13, 1,0,0,0, 1, 0,0,0, 5,3));  // 39 C r13
        tbl.push_back(mk(1,11,12, 9, 1,0,0,1, 1, 0,0,0, 5,3));  // 40 reset
        tbl.push_back(mk(0, 0, 0, 0, 0,0,0,0, 1, 0,0,0, 0,0));  // 41 cleared
        tbl.push_back(mk(1,11,12, 9, 1,0,0,0, 1, 0,0,0, 0,0));  // 42 reader
        tbl.push_back(mk(0, 0, 0, 0, 0,0,0,0, 1, 0,0,0, 0,0));  // 43 no fwd

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            drive(tbl[i]);
            sb.push_back(tbl[i]);
            @(negedge clk);
            e = sb.pop_front();
            if (e.chk) begin
                check($sformatf("v%0d fwd_a", i), int'(fwd_a), int'(e.ea));
                check($sformatf("v%0d fwd_b", i), int'(fwd_b), int'(e.eb));
                check($sformatf("v%0d stall", i), int'(stall), int'(e.es));
                check($sformatf("v%0d cnt", i), int'(cnt), e.ec);
                check($sformatf("v%0d cnt_sat", i), int'(cnt_s), e.ecs);
            end
        end

        // Reset coinciding with a load-use stall: stall is visible in that
        // cycle, but the counter must come out of reset at zero.
        @(posedge clk); #1;
        drive(mk(1, 1, 1, 6, 1,1,0,0, 0, 0,0,0, 0,0));          // load r6
        @(posedge clk); #1;
        drive(mk(1, 6, 3, 9, 1,0,0,1, 0, 0,0,0, 0,0));          // reader + rst
        @(negedge clk);
        check("rst_stall pre", int'(stall), 1);
        @(posedge clk); #1;
        drive(mk(1, 6, 3, 9, 1,0,0,0, 0, 0,0,0, 0,0));          // re-present
        @(negedge clk);
        check("rst_stall cnt", int'(cnt), 0);
        check("rst_stall post", int'(stall), 0);
        @(posedge clk); #1;
        drive(mk(0, 0, 0, 0, 0,0,0,0, 0, 0,0,0, 0,0));
        @(negedge clk);
        check("rst_stall fwd_a", int'(fwd_a), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
